// File: rtl/multi_debouncer_pkg.sv
// Shared definitions for the multi-channel button conditioner: per-channel FSM
// state encoding and default timing for a 100 MHz system clock.
package multi_debouncer_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } deb_state_t;

   localparam int DEF_CHANNELS      = 5;
   localparam int DEF_STABLE_CYCLES = 1_000_000;    // 10 ms
   localparam int DEF_LONG_CYCLES   = 100_000_000;  // 1 s
   localparam int DEF_REPEAT_CYCLES = 20_000_000;   // 200 ms

endpackage

// File: rtl/multi_debouncer_channel.sv
// One button channel: two-flop synchroniser, symmetric press/release stability
// filter, and hold timing that produces long-press and auto-repeat strobes.
module multi_debouncer_channel
   import multi_debouncer_pkg::*;
#(
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter bit REPEAT_EN     = 1'b1,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic ori_but,
   output logic deb_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic rep_pulse
);

   localparam int STAB_W = $clog2(STABLE_CYCLES) + 1;
   localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
   localparam int REP_W  = $clog2(REPEAT_CYCLES) + 1;

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 2);
   localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

   logic              but_in;
   logic              s1;
   logic              s2;
   deb_state_t        state;
   deb_state_t        state_nxt;
   logic [STAB_W-1:0] stab_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [REP_W-1:0]  rep_cnt;
   logic              stab_last;
   logic              long_done;
   logic              rep_last;
   logic              press_nxt;
   logic              release_nxt;
   logic              long_nxt;
   logic              rep_nxt;

   function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
      return (v == HOLD_LAST) ? v : v + 1'b1;
   endfunction

   function automatic logic [REP_W-1:0] rep_wrap_inc(input logic [REP_W-1:0] v);
      return (v == REP_LAST) ? '0 : v + 1'b1;
   endfunction

   // Polarity is normalised before the synchroniser so everything downstream sees 1 = pressed.
   assign but_in = ACTIVE_LOW ? ~ori_but : ori_but;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= but_in;
         s2 <= s1;
      end
   end

   assign stab_last = (stab_cnt == STAB_LAST);
   assign long_done = (hold_cnt == HOLD_LAST);
   assign rep_last  = (rep_cnt == REP_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= RELEASED;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
         RELEASED: begin
            if (s2) state_nxt = PRESS_CHK;
         end
         PRESS_CHK: begin
            if (!s2) begin
               state_nxt = RELEASED;
            end else if (stab_last) begin
               state_nxt = PRESSED;
               press_nxt = 1'b1;
            end
         end
         PRESSED: begin
            if (!s2) state_nxt = RELEASE_CHK;
         end
         RELEASE_CHK: begin
            if (s2) begin
               state_nxt = PRESSED;
            end else if (stab_last) begin
               state_nxt   = RELEASED;
               release_nxt = 1'b1;
            end
         end
         default: state_nxt = RELEASED;
      endcase
   end

   // hold_cnt saturates at LONG_CYCLES-1, so the long strobe can only fire once per press.
   assign long_nxt = (state == PRESSED) && (hold_cnt == HOLD_PRE);
   assign rep_nxt  = REPEAT_EN && (state == PRESSED) && long_done && rep_last;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stab_cnt      <= '0;
         hold_cnt      <= '0;
         rep_cnt       <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         rep_pulse     <= 1'b0;
      end else begin
         press_pulse   <= press_nxt;
         release_pulse <= release_nxt;
         long_pulse    <= long_nxt;
         rep_pulse     <= rep_nxt;

         case (state)
            RELEASED:  stab_cnt <= STAB_W'(s2);
            PRESS_CHK: stab_cnt <= (!s2 || stab_last) ? '0 : stab_cnt + 1'b1;
            PRESSED:   stab_cnt <= STAB_W'(!s2);
            default:   stab_cnt <= (s2 || stab_last) ? '0 : stab_cnt + 1'b1;
         endcase

         if (press_nxt)               hold_cnt <= '0;
         else if (state == PRESSED)   hold_cnt <= hold_sat_inc(hold_cnt);

         // Repeat phase is frozen during a release check and restarts only from RELEASED.
         if (state == RELEASED)                   rep_cnt <= '0;
         else if ((state == PRESSED) && long_done) rep_cnt <= rep_wrap_inc(rep_cnt);
      end
   end

   assign deb_level = (state == PRESSED) || (state == RELEASE_CHK);

endmodule

// File: rtl/multi_debouncer.sv
// N-channel button conditioner: one independent debounce channel per input,
// plus a combined any-pressed indication.
module multi_debouncer
   import multi_debouncer_pkg::*;
#(
   parameter int CHANNELS      = DEF_CHANNELS,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter bit REPEAT_EN     = 1'b1,
   parameter bit ACTIVE_LOW    = 1'b0
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [CHANNELS-1:0] ori_but,
   output logic [CHANNELS-1:0] deb_level,
   output logic [CHANNELS-1:0] press_pulse,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] long_pulse,
   output logic [CHANNELS-1:0] rep_pulse,
   output logic                any_pressed
);

   if (CHANNELS < 1) begin : g_bad_channels
      $error("multi_debouncer: CHANNELS must be >= 1");
   end
   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("multi_debouncer: STABLE_CYCLES must be >= 2");
   end
   if (LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_long
      $error("multi_debouncer: LONG_CYCLES must exceed STABLE_CYCLES");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_repeat
      $error("multi_debouncer: REPEAT_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      multi_debouncer_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .LONG_CYCLES   (LONG_CYCLES),
         .REPEAT_CYCLES (REPEAT_CYCLES),
         .REPEAT_EN     (REPEAT_EN),
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_debounce_channel (
         .clk           (clk),
         .rstn          (rstn),
         .ori_but       (ori_but[i]),
         .deb_level     (deb_level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i]),
         .long_pulse    (long_pulse[i]),
         .rep_pulse     (rep_pulse[i])
      );
   end

   assign any_pressed = |deb_level;

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: two instances (active-high with repeat,
// active-low without repeat) driven by directed and random button activity.
module tb_multi_debouncer;

   localparam int CH = 3;
   localparam int ST = 4;
   localparam int LG = 20;
   localparam int RP = 5;

   typedef struct packed {
      logic [CH-1:0] lvl;
      logic [CH-1:0] prs;
      logic [CH-1:0] rel;
      logic [CH-1:0] lng;
      logic [CH-1:0] rep;
      logic          any;
   } exp_t;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic [CH-1:0] but_a = '0;
   logic [CH-1:0] but_b;
   logic [CH-1:0] lvl_a, prs_a, rel_a, lng_a, rep_a;
   logic [CH-1:0] lvl_b, prs_b, rel_b, lng_b, rep_b;
   logic          any_a, any_b;

   int   checks   = 0;
   int   failures = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   // Reference state: [0] = active-high/repeat instance, [1] = active-low/no-repeat instance.
   bit m_s1   [2][CH];
   bit m_s2   [2][CH];
   bit m_lvl  [2][CH];
   int m_run  [2][CH];
   int m_hold [2][CH];
   int m_since[2][CH];

   assign but_b = ~but_a;

   always #5 clk = ~clk;

   multi_debouncer #(
      .CHANNELS(CH), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP),
      .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
   ) dut_a (
      .clk(clk), .rstn(rstn), .ori_but(but_a), .deb_level(lvl_a), .press_pulse(prs_a),
      .release_pulse(rel_a), .long_pulse(lng_a), .rep_pulse(rep_a), .any_pressed(any_a)
   );

   multi_debouncer #(
      .CHANNELS(CH), .STABLE_CYCLES(ST), .LONG_CYCLES(LG), .REPEAT_CYCLES(RP),
      .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
   ) dut_b (
      .clk(clk), .rstn(rstn), .ori_but(but_b), .deb_level(lvl_b), .press_pulse(prs_b),
      .release_pulse(rel_b), .long_pulse(lng_b), .rep_pulse(rep_b), .any_pressed(any_b)
   );

   // Level flips after ST consecutive synchronised samples that disagree with it;
   // hold time accrues only while pressed with no release candidate pending.
   task automatic model_edge(input int d, input bit rep_en, input bit act_low,
                             input logic [CH-1:0] raw, input bit rst, output exp_t e);
      bit s2;
      bit held;
      e = '0;
      for (int c = 0; c < CH; c++) begin
         if (rst) begin
            m_s1[d][c] = 1'b0; m_s2[d][c] = 1'b0; m_lvl[d][c] = 1'b0;
            m_run[d][c] = 0; m_hold[d][c] = 0; m_since[d][c] = 0;
         end else begin
            s2   = m_s2[d][c];
            held = m_lvl[d][c] && (m_run[d][c] == 0);
            if (s2 != m_lvl[d][c]) begin
               m_run[d][c]++;
               if (m_run[d][c] == ST) begin
                  m_run[d][c] = 0;
                  m_lvl[d][c] = ~m_lvl[d][c];
                  if (m_lvl[d][c]) begin
                     e.prs[c] = 1'b1;
                     m_hold[d][c]  = 0;
                     m_since[d][c] = 0;
                  end else begin
                     e.rel[c] = 1'b1;
                  end
               end
            end else begin
               m_run[d][c] = 0;
            end
            if (held) begin
               if (m_hold[d][c] < LG - 1) begin
                  m_hold[d][c]++;
                  if (m_hold[d][c] == LG - 1) e.lng[c] = 1'b1;
               end else begin
                  m_since[d][c]++;
                  if (m_since[d][c] == RP) begin
                     m_since[d][c] = 0;
                     if (rep_en) e.rep[c] = 1'b1;
                  end
               end
            end
            m_s2[d][c] = m_s1[d][c];
            m_s1[d][c] = act_low ? ~raw[c] : raw[c];
         end
         e.lvl[c] = m_lvl[d][c];
      end
      e.any = |e.lvl;
   endtask

   task automatic compare(input string nm, input exp_t got, input exp_t req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s t=%0t got lvl=%b prs=%b rel=%b lng=%b rep=%b any=%b required lvl=%b prs=%b rel=%b lng=%b rep=%b any=%b",
                  nm, $time, got.lvl, got.prs, got.rel, got.lng, got.rep, got.any,
                  req.lvl, req.prs, req.rel, req.lng, req.rep, req.any);
      end
   endtask

   // Model: sample what the DUT sampled at the edge, settle after any reset change, queue expectation.
   initial begin : model
      logic [CH-1:0] ra;
      logic [CH-1:0] rb;
      logic          r0;
      exp_t          ea;
      exp_t          eb;
      forever begin
         @(posedge clk);
         ra = but_a;
         rb = but_b;
         r0 = rstn;
         #3;
         model_edge(0, 1'b1, 1'b0, ra, !(r0 && rstn), ea);
         model_edge(1, 1'b0, 1'b1, rb, !(r0 && rstn), eb);
         q_a.push_back(ea);
         q_b.push_back(eb);
      end
   end

   initial begin : monitor
      exp_t got;
      forever begin
         @(negedge clk);
         if (q_a.size() == 0 || q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL queue t=%0t got empty expectation queue required one entry", $time);
         end else begin
            got = '{lvl: lvl_a, prs: prs_a, rel: rel_a, lng: lng_a, rep: rep_a, any: any_a};
            compare("dut_a", got, q_a.pop_front());
            got = '{lvl: lvl_b, prs: prs_b, rel: rel_b, lng: lng_b, rep: rep_b, any: any_b};
            compare("dut_b", got, q_b.pop_front());
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Counts sampling edges from now until the selected strobe of dut_a appears.
   task automatic latency(input string nm, input int ch, input bit rel, input int req);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         seen = rel ? rel_a[ch] : prs_a[ch];
      end
      checks++;
      if (!seen || n != req) begin
         failures++;
         $display("FAIL %s latency got=%0d edges (seen=%0d) required=%0d", nm, n, seen, req);
      end
      @(posedge clk);
      #2;
   endtask

   initial begin : stim
      int rem[CH];
      rstn  = 1'b0;
      but_a = '0;
      step(3);
      rstn = 1'b1;
      step(3);

      // Clean press on ch0, then release.
      but_a[0] = 1'b1;
      latency("press_ch0", 0, 1'b0, ST + 2);
      step(3);
      but_a[0] = 1'b0;
      latency("release_ch0", 0, 1'b1, ST + 2);
      step(4);

      // Bounce on ch1 never qualifies.
      but_a[1] = 1'b1; step(3);
      but_a[1] = 1'b0; step(1);
      but_a[1] = 1'b1; step(3);
      but_a[1] = 1'b0; step(10);

      // Short release glitch on ch0 while pressed.
      but_a[0] = 1'b1; step(12);
      but_a[0] = 1'b0; step(2);
      but_a[0] = 1'b1; step(10);
      but_a[0] = 1'b0; step(10);

      // Long press with auto-repeat on ch2.
      but_a[2] = 1'b1; step(ST + 2 + 45);
      but_a[2] = 1'b0; step(15);

      // Simultaneous presses.
      but_a = '1; step(30);
      but_a = '0; step(12);

      // Reset while ch0 held.
      but_a[0] = 1'b1; step(12);
      rstn = 1'b0; step(2);
      rstn = 1'b1;
      latency("press_after_reset", 0, 1'b0, ST + 2);
      step(5);
      but_a[0] = 1'b0; step(10);

      // Random bouncing, holds and occasional resets.
      for (int c = 0; c < CH; c++) rem[c] = 0;
      for (int k = 0; k < 1500; k++) begin
         for (int c = 0; c < CH; c++) begin
            if (rem[c] == 0) begin
               but_a[c] = ~but_a[c];
               case ($urandom_range(0, 2))
                  0:       rem[c] = int'($urandom_range(1, 3));
                  1:       rem[c] = int'($urandom_range(4, 10));
                  default: rem[c] = int'($urandom_range(20, 60));
               endcase
            end else begin
               rem[c]--;
            end
         end
         rstn = (rstn == 1'b0) ? 1'b1 : ($urandom_range(0, 399) != 0);
         step(1);
      end

      rstn  = 1'b1;
      but_a = '0;
      step(20);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
